// File: rtl/rs_dec_pkg.sv
// rtl/rs_dec_pkg.sv - shared RS decoder sizes and stage state encodings
package rs_dec_pkg;

  localparam int N_BLK_DEF = 204;
  localparam int K_DAT_DEF = 188;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } in_state_e;

endpackage

// File: rtl/in_stage.sv
// rtl/in_stage.sv - RS decoder input stage: frames received bytes into codewords,
// stores data bytes to a ping-pong memory and forwards every byte to the syndrome stage
module in_stage
  import rs_dec_pkg::*;
#(
  parameter int N_BLK = N_BLK_DEF,
  parameter int K_DAT = K_DAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       start_blk,
  input  logic [7:0] In_byte,
  output logic       WE,
  output logic [7:0] WrAdd,
  output logic [7:0] WrData,
  output logic       WrBank,
  output logic [7:0] S_byte,
  output logic       S_valid,
  output logic       in_done,
  output logic       sync_err
);

  localparam logic [7:0] LAST_IDX = 8'(N_BLK - 1);
  localparam logic [7:0] DATA_LEN = 8'(K_DAT);

  in_state_e  r_state;
  logic [7:0] r_cnt;

  logic       w_accept;
  logic [7:0] w_idx;
  logic       w_last;

  // start_blk always restarts at byte 0, so in RECV it resynchronises the frame
  assign w_accept = CE && (start_blk || (r_state == ST_RECV));
  assign w_idx    = start_blk ? 8'd0 : r_cnt;
  assign w_last   = (w_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      WE       <= 1'b0;
      WrAdd    <= 8'd0;
      WrData   <= 8'd0;
      WrBank   <= 1'b0;
      S_byte   <= 8'd0;
      S_valid  <= 1'b0;
      in_done  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      WE      <= 1'b0;
      S_valid <= 1'b0;
      in_done <= 1'b0;
      if (w_accept) begin
        S_valid <= 1'b1;
        S_byte  <= In_byte;
        if (w_idx < DATA_LEN) begin
          WE     <= 1'b1;
          WrAdd  <= w_idx;
          WrData <= In_byte;
        end
        if (start_blk && (r_state == ST_RECV)) begin
          sync_err <= 1'b1;
        end
        // bank flips with the last parity byte, long after the final data write
        if (w_last) begin
          in_done <= 1'b1;
          WrBank  <= ~WrBank;
          r_cnt   <= 8'd0;
          r_state <= ST_IDLE;
        end else begin
          r_cnt   <= w_idx + 8'd1;
          r_state <= ST_RECV;
        end
      end
    end
  end

endmodule

// File: tb/tb_in_stage.sv
// tb/tb_in_stage.sv - randomized self-checking bench for in_stage against a codeword-position model
module tb_in_stage;

  localparam int N = 204;
  localparam int K = 188;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       CE = 1'b0;
  logic       start_blk = 1'b0;
  logic [7:0] In_byte = 8'd0;
  logic       WE;
  logic [7:0] WrAdd;
  logic [7:0] WrData;
  logic       WrBank;
  logic [7:0] S_byte;
  logic       S_valid;
  logic       in_done;
  logic       sync_err;

  in_stage #(.N_BLK(N), .K_DAT(K)) dut (
    .clk(clk), .reset(reset), .CE(CE), .start_blk(start_blk), .In_byte(In_byte),
    .WE(WE), .WrAdd(WrAdd), .WrData(WrData), .WrBank(WrBank),
    .S_byte(S_byte), .S_valid(S_valid), .in_done(in_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: position inside the current codeword, -1 when no codeword is open
  int pos = -1;
  int e_we = 0, e_wradd = 0, e_wrdata = 0, e_bank = 0;
  int e_sbyte = 0, e_sv = 0, e_done = 0, e_serr = 0;
  int prev_sv = 0;

  int we_cnt = 0, sv_cnt = 0, done_cnt = 0, we_b1_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      pos = -1;
      e_we = 0; e_wradd = 0; e_wrdata = 0; e_bank = 0;
      e_sbyte = 0; e_sv = 0; e_done = 0; e_serr = 0;
    end else begin
      e_we = 0; e_sv = 0; e_done = 0;
      if (CE) begin
        if (start_blk) begin
          if (pos >= 0) e_serr = 1;
          pos = 0;
        end
        if (pos >= 0) begin
          e_sv = 1;
          e_sbyte = int'(In_byte);
          if (pos < K) begin
            e_we = 1; e_wradd = pos; e_wrdata = int'(In_byte);
          end
          if (pos == N - 1) begin
            e_done = 1; e_bank = 1 - e_bank; pos = -1;
          end else begin
            pos++;
          end
        end
      end
    end
    chk("WE", int'(WE), e_we);
    chk("WrAdd", int'(WrAdd), e_wradd);
    chk("WrData", int'(WrData), e_wrdata);
    chk("WrBank", int'(WrBank), e_bank);
    chk("S_byte", int'(S_byte), e_sbyte);
    chk("S_valid", int'(S_valid), e_sv);
    chk("in_done", int'(in_done), e_done);
    chk("sync_err", int'(sync_err), e_serr);
    if (prev_sv && S_valid) chk("S_valid_double", 1, 0);
    prev_sv = int'(S_valid);
    we_cnt += int'(WE);
    sv_cnt += int'(S_valid);
    done_cnt += int'(in_done);
    if (WE && WrBank) we_b1_cnt++;
  end

  task automatic idle(input int n, input bit stray);
    repeat (n) begin
      @(negedge clk);
      CE = 1'b0;
      start_blk = stray ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  // one strobe plus at least seven quiet clocks
  task automatic send(input logic [7:0] d, input bit sb, input int gap, input bit stray);
    @(negedge clk);
    CE = 1'b1; start_blk = sb; In_byte = d;
    idle(gap, stray);
  endtask

  task automatic send_cw(input int from, input int to, input bit first_sb);
    for (int i = from; i <= to; i++) send(8'(i), (i == from) && first_sb, 7, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_WE", int'(WE), 0);
    chk("rst_WrAdd", int'(WrAdd), 0);
    chk("rst_WrData", int'(WrData), 0);
    chk("rst_WrBank", int'(WrBank), 0);
    chk("rst_S_byte", int'(S_byte), 0);
    chk("rst_S_valid", int'(S_valid), 0);
    chk("rst_in_done", int'(in_done), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  int b_we, b_sv, b_dn, b_b1;

  task automatic snap();
    b_we = we_cnt; b_sv = sv_cnt; b_dn = done_cnt; b_b1 = we_b1_cnt;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // single codeword, value = index
    snap();
    send_cw(0, N - 1, 1'b1);
    chk("cw1_we_pulses", we_cnt - b_we, 188);
    chk("cw1_sv_pulses", sv_cnt - b_sv, 204);
    chk("cw1_done", done_cnt - b_dn, 1);
    chk("cw1_bank", int'(WrBank), 1);
    chk("cw1_last_addr", int'(WrAdd), 187);
    chk("cw1_last_data", int'(WrData), 187);
    chk("cw1_last_sbyte", int'(S_byte), 203);

    // two back-to-back codewords from reset
    do_reset();
    snap();
    send_cw(0, N - 1, 1'b1);
    send_cw(0, N - 1, 1'b1);
    chk("b2b_done", done_cnt - b_dn, 2);
    chk("b2b_bank1_writes", we_b1_cnt - b_b1, 188);
    chk("b2b_bank", int'(WrBank), 0);

    // strobes without start in IDLE are dropped
    snap();
    for (int i = 0; i < 5; i++) send(8'(200 + i), 1'b0, 7, 1'b0);
    chk("idle_sv", sv_cnt - b_sv, 0);
    send_cw(0, N - 1, 1'b1);
    chk("idle_cw_we", we_cnt - b_we, 188);
    chk("idle_cw_bank", int'(WrBank), 1);

    // resync at byte 100
    snap();
    send_cw(0, 99, 1'b1);
    send_cw(0, 99, 1'b1);
    chk("resync_err", int'(sync_err), 1);
    chk("resync_bank_mid", int'(WrBank), 1);
    send_cw(100, N - 1, 1'b0);
    chk("resync_done", done_cnt - b_dn, 1);
    chk("resync_we", we_cnt - b_we, 100 + 188);
    chk("resync_bank", int'(WrBank), 0);

    // reset in mid codeword
    send_cw(0, 49, 1'b1);
    do_reset();
    snap();
    send_cw(0, N - 1, 1'b1);
    chk("post_rst_b1_writes", we_b1_cnt - b_b1, 0);
    chk("post_rst_we", we_cnt - b_we, 188);
    chk("post_rst_bank", int'(WrBank), 1);

    // random traffic: random data, gaps, stray start_blk and occasional resyncs
    for (int i = 0; i < 2500; i++) begin
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 299) == 0) || (i == 0),
           $urandom_range(7, 12), 1'b1);
    end
    idle(10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
